// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: bundle layouts, exception bit indices and ecodes.
// Used by the MEM, WB and CSR stages.
package cpu_pkg;

  localparam int RF_ALL_W  = 53;
  localparam int CSR_RF_W  = 79;
  localparam int EXC_W     = 7;

  // Exception bundle bit indices, {INT, ADEF, ALE, BRK, INE, SYS, ertn}
  localparam int EXC_INT   = 6;
  localparam int EXC_ADEF  = 5;
  localparam int EXC_ALE   = 4;
  localparam int EXC_BRK   = 3;
  localparam int EXC_INE   = 2;
  localparam int EXC_SYS   = 1;
  localparam int EXC_ERTN  = 0;

  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0B,
    ECODE_BRK  = 6'h0C,
    ECODE_INE  = 6'h0D
  } ecode_e;

  typedef struct packed {
    logic        csr_we;
    logic [13:0] csr_num;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
  } rf_all_t;

  typedef struct packed {
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
  } csr_rf_t;

endpackage

// File: rtl/wb_stage_if.sv
// MEM -> WB handshake and payload bus.
interface wb_stage_if;
  import cpu_pkg::*;

  logic                mem_to_wb_valid;
  logic                wb_allowin;
  logic [31:0]         mem_pc;
  logic [RF_ALL_W-1:0] mem_rf_all;
  logic [EXC_W-1:0]    mem_exc_rf;
  logic [CSR_RF_W-1:0] mem_csr_rf;
  logic [31:0]         mem_fault_vaddr;

  modport master (
    output mem_to_wb_valid, mem_pc, mem_rf_all, mem_exc_rf, mem_csr_rf, mem_fault_vaddr,
    input  wb_allowin
  );

  modport slave (
    input  mem_to_wb_valid, mem_pc, mem_rf_all, mem_exc_rf, mem_csr_rf, mem_fault_vaddr,
    output wb_allowin
  );

endinterface

// File: rtl/wb_exc_encode.sv
// Exception priority encoder: INT > ADEF > ALE > BRK > INE > SYS.
module wb_exc_encode
  import cpu_pkg::*;
(
  input  logic                 valid,
  input  logic [EXC_W-1:1]     cause,
  input  logic [31:0]          pc,
  input  logic [31:0]          fault_vaddr,
  output logic                 ex,
  output logic [5:0]           ecode,
  output logic [8:0]           esubcode,
  output logic                 badv_we,
  output logic [31:0]          badv
);

  assign esubcode = 9'd0;

  always_comb begin
    ex      = 1'b0;
    ecode   = ECODE_INT;
    badv_we = 1'b0;
    badv    = '0;
    if (valid && (|cause)) begin
      ex = 1'b1;
      if (cause[EXC_INT]) begin
        ecode = ECODE_INT;
      end else if (cause[EXC_ADEF]) begin
        ecode   = ECODE_ADEF;
        badv_we = 1'b1;
        badv    = pc;
      end else if (cause[EXC_ALE]) begin
        ecode   = ECODE_ALE;
        badv_we = 1'b1;
        badv    = fault_vaddr;
      end else if (cause[EXC_BRK]) begin
        ecode = ECODE_BRK;
      end else if (cause[EXC_INE]) begin
        ecode = ECODE_INE;
      end else begin
        ecode = ECODE_SYS;
      end
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: commits register/CSR writes and raises exception or ertn
// flushes toward the earlier stages in the same cycle as the offending instruction.
module wb_stage
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  wb_stage_if.slave           mem,
  output logic                rf_we,
  output logic [4:0]          rf_waddr,
  output logic [31:0]         rf_wdata,
  output logic [RF_ALL_W-1:0] wb_rf_all,
  output logic                wb_valid,
  output logic                csr_we,
  output logic [13:0]         csr_num,
  output logic [31:0]         csr_wmask,
  output logic [31:0]         csr_wvalue,
  output logic                wb_ex,
  output logic [5:0]          wb_ecode,
  output logic [8:0]          wb_esubcode,
  output logic [31:0]         wb_ex_pc,
  output logic                wb_badv_we,
  output logic [31:0]         wb_badv,
  output logic                ertn_flush,
  output logic                cancel_exc_ertn,
  output logic [31:0]         debug_wb_pc,
  output logic [3:0]          debug_wb_rf_we,
  output logic [4:0]          debug_wb_rf_wnum,
  output logic [31:0]         debug_wb_rf_wdata
);

  logic             vld_p1;
  logic [31:0]      pc_p1;
  rf_all_t          rf_p1;
  logic [EXC_W-1:0] exc_p1;
  csr_rf_t          csr_p1;
  logic [31:0]      fault_p1;

  logic vld;
  logic wb_ready_go;
  logic allowin;
  logic accept;
  logic rf_commit;
  logic csr_commit;
  logic rfall_csr_commit;

  assign wb_ready_go = 1'b1;
  // Outputs are forced quiet while reset is held, not just after the reset edge.
  assign vld         = vld_p1 & resetn;
  assign allowin     = ~vld | wb_ready_go | cancel_exc_ertn;
  assign accept      = mem.mem_to_wb_valid & allowin;
  assign mem.wb_allowin = allowin;

  // MEM -> WB register stage
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1   <= 1'b0;
      pc_p1    <= '0;
      rf_p1    <= '0;
      exc_p1   <= '0;
      csr_p1   <= '0;
      fault_p1 <= '0;
    end else if (cancel_exc_ertn) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        pc_p1    <= mem.mem_pc;
        rf_p1    <= mem.mem_rf_all;
        exc_p1   <= mem.mem_exc_rf;
        csr_p1   <= mem.mem_csr_rf;
        fault_p1 <= mem.mem_fault_vaddr;
      end
    end
  end

  // Commit / flush stage (combinational from the latched payload)
  wb_exc_encode u_exc_encode (
    .valid       (vld),
    .cause       (exc_p1[EXC_W-1:1]),
    .pc          (pc_p1),
    .fault_vaddr (fault_p1),
    .ex          (wb_ex),
    .ecode       (wb_ecode),
    .esubcode    (wb_esubcode),
    .badv_we     (wb_badv_we),
    .badv        (wb_badv)
  );

  assign ertn_flush      = vld & exc_p1[EXC_ERTN] & ~wb_ex;
  assign cancel_exc_ertn = wb_ex | ertn_flush;

  assign rf_commit        = vld & rf_p1.rf_we  & ~wb_ex;
  assign csr_commit       = vld & csr_p1.csr_we & ~wb_ex;
  assign rfall_csr_commit = vld & rf_p1.csr_we  & ~wb_ex;

  assign wb_valid   = vld;
  assign rf_we      = rf_commit;
  assign rf_waddr   = resetn ? rf_p1.rf_waddr : '0;
  assign rf_wdata   = resetn ? rf_p1.rf_wdata : '0;
  assign csr_we     = csr_commit;
  assign csr_num    = resetn ? csr_p1.csr_num    : '0;
  assign csr_wmask  = resetn ? csr_p1.csr_wmask  : '0;
  assign csr_wvalue = resetn ? csr_p1.csr_wvalue : '0;
  assign wb_ex_pc   = resetn ? pc_p1 : '0;

  assign wb_rf_all = {rfall_csr_commit,
                      (resetn ? rf_p1.csr_num : 14'd0),
                      rf_commit, rf_waddr, rf_wdata};

  assign debug_wb_pc       = resetn ? pc_p1 : '0;
  assign debug_wb_rf_we    = {4{rf_commit}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have ports: clk in 1 clock; resetn in 1, synchronous, active-low.
REQ-002 SHALL have: wb_allowin out 1, stage accepts MEM payload this cycle; mem_to_wb_valid in 1, MEM payload valid.
REQ-003 SHALL have: mem_pc in 32, instruction PC; mem_rf_all in 53, {csr_we, csr_num[13:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}.
REQ-004 SHALL have: mem_exc_rf in 7, {INT, ADEF, ALE, BRK, INE, SYS, ertn}; mem_csr_rf in 79, {csr_we, csr_num[13:0], csr_wmask[31:0], csr_wvalue[31:0]}; mem_fault_vaddr in 32, ALE address.
REQ-005 SHALL have: rf_we out 1; rf_waddr out 5; rf_wdata out 32, register-file write port.
REQ-006 SHALL have: wb_rf_all out 53, same layout as mem_rf_all, qualified for bypass/hazard use; wb_valid out 1.
REQ-007 SHALL have: csr_we out 1; csr_num out 14; csr_wmask out 32; csr_wvalue out 32, CSR write port.
REQ-008 SHALL have: wb_ex out 1; wb_ecode out 6; wb_esubcode out 9; wb_ex_pc out 32; wb_badv_we out 1; wb_badv out 32; ertn_flush out 1; cancel_exc_ertn out 1, pipeline flush to IF/ID/EXE/MEM.
REQ-009 SHALL have: debug_wb_pc out 32; debug_wb_rf_we out 4; debug_wb_rf_wnum out 5; debug_wb_rf_wdata out 32.

Function
REQ-010 SHALL set wb_ready_go = 1; wb_allowin = ~wb_valid | wb_ready_go | cancel_exc_ertn.
REQ-011 SHALL, each cycle when not in reset and cancel_exc_ertn = 0, load wb_valid <= mem_to_wb_valid & wb_allowin.
REQ-012 SHALL capture mem_pc, mem_rf_all, mem_exc_rf, mem_csr_rf and mem_fault_vaddr only when mem_to_wb_valid & wb_allowin; otherwise hold.
REQ-013 SHALL compute any_exc = wb_valid & |exc[6:1]; wb_ex = any_exc.
REQ-014 SHALL compute ertn_flush = wb_valid & exc[0] & ~any_exc.
REQ-015 SHALL drive cancel_exc_ertn = wb_ex | ertn_flush, combinational, in the same cycle as the offending instruction.
REQ-016 SHALL prioritize exceptions INT > ADEF > ALE > BRK > INE > SYS.
REQ-017 SHALL encode ecode INT=0x00, ADEF=0x08, ALE=0x09, SYS=0x0B, BRK=0x0C, INE=0x0D; esubcode = 0 for all.
REQ-018 SHALL drive wb_ex_pc = latched PC.
REQ-019 SHALL assert wb_badv_we for ADEF (wb_badv = PC) or ALE (wb_badv = latched fault vaddr) only; otherwise wb_badv_we = 0 and wb_badv = 0.
REQ-020 SHALL drive rf_we = wb_valid & payload rf_we & ~wb_ex, and csr_we = wb_valid & payload csr_we & ~wb_ex; an excepting instruction commits nothing.
REQ-021 SHALL commit ertn register/CSR writes, since ertn carries none.
REQ-022 SHALL drive wb_rf_all with its rf_we and csr_we fields masked identically to REQ-020.
REQ-023 SHALL drive debug_wb_rf_we = {4{rf_we}}, debug_wb_pc = latched PC, and wnum/wdata = rf_waddr/rf_wdata.
REQ-024 SHALL clear wb_valid at the next edge after cancel_exc_ertn, and SHALL NOT accept the MEM payload presented in the flush cycle.
REQ-025 SHALL give cancel priority when mem_to_wb_valid and cancel_exc_ertn coincide; the result is wb_valid = 0.
REQ-026 SHALL produce a back-to-back flush from the second of two adjacent excepting instructions only if MEM presents it after the flush; normally it is discarded.
REQ-027 SHALL have no input-to-output latency beyond one register stage; outputs are valid in the cycle after capture.

Reset
REQ-028 SHALL, when resetn = 0 at an edge, force wb_valid = 0 and clear latched PC, rf, exc and csr fields to 0.
REQ-029 SHALL hold all commit, flush and debug outputs at 0 during reset.
REQ-030 SHALL take reset over any concurrent capture when reset is asserted mid-operation.

Structure
REQ-031 SHALL place ecode constants, exception bit indices and bundle field offsets (53/79/7-bit layouts) in shared package cpu_pkg, also used by MEM and CSR.
REQ-032 SHALL implement the priority encoder (REQ-016/017/019) as sub-module wb_exc_encode.
REQ-033 SHALL contain no other sub-modules.

Verification
REQ-034 SHALL cover: valid add, pc=0x1C000100, rf_we=1, waddr=5, wdata=0x12345678 -> next cycle rf_we=1, debug_wb_rf_we=0xF, debug_wb_pc=0x1C000100.
REQ-035 SHALL cover: ALE + SYS together, fault vaddr=0x00000803 -> wb_ex=1, ecode=0x09, wb_badv=0x00000803, rf_we=0, cancel_exc_ertn=1 for one cycle.
REQ-036 SHALL cover: ertn with csr_we=1 -> ertn_flush=1, wb_ex=0, csr_we=1, cancel=1; next cycle wb_valid=0.
REQ-037 SHALL cover: mem_to_wb_valid=1 in the flush cycle -> wb_valid=0 next cycle, no rf_we.
REQ-038 SHALL cover: resetn=0 mid-stream with a valid instruction latched -> all outputs 0 next cycle, wb_allowin=1.
REQ-039 SHALL cover: ADEF, pc=0x1C000002 -> ecode=0x08, wb_badv=0x1C000002, wb_badv_we=1.
